module_alu_seq: RTL and testbench

MODULE_ALU_SEQ -- requirements
Module: module_alu_seq

---
 rtl/module_alu_seq.sv | 150 +++++++++++++++
 tb/tb_module_alu_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/module_alu_seq.sv
// module_alu_seq: sequential ALU with a multi-cycle shift-add multiply and optional saturation
module module_alu_seq #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 6,
    parameter int SAT_EN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic              imm_sign,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              store_en,
    output logic              flag_zero,
    output logic              flag_neg,
    output logic              flag_ovf
);
    localparam int PW = DATA_W + IMM_W;
    localparam int TW = PW + 1;
    localparam int CW = $clog2(IMM_W);
    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_SUBI = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DISP = 3'd7;
    typedef enum logic [1:0] {IDLE, EXEC, MUL_ITER, DONE} state_t;
    state_t            r_state;
    logic [2:0]        r_op;
    logic              r_imm_sign;
    logic [IMM_W-1:0]  r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_mcand;
    logic [IMM_W-1:0]  r_mplier;
    logic [CW-1:0]     r_cnt;
    logic              r_neg;
    logic [DATA_W-1:0] r_result;
    logic              r_valid;
    logic              r_store;
    logic              r_zero;
    logic              r_negf;
    logic              r_ovf;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_simm;
    logic [TW-1:0]     w_a_x;
    logic [TW-1:0]     w_b_x;
    logic [TW-1:0]     w_s_x;
    logic [TW-1:0]     w_prod;
    logic [TW-1:0]     w_true;
    logic [PW-DATA_W+1:0] w_hi;
    logic              w_ovf;
    logic [DATA_W-1:0] w_res;
    // Operands are widened so the exact mathematical result is available before narrowing
    always_comb begin
        w_a_mag = src_a[DATA_W-1] ? -src_a : src_a;
        w_simm  = r_imm_sign ? -{{(DATA_W-IMM_W){1'b0}}, r_imm} : {{(DATA_W-IMM_W){1'b0}}, r_imm};
        w_a_x   = {{(TW-DATA_W){r_a[DATA_W-1]}}, r_a};
        w_b_x   = {{(TW-DATA_W){r_b[DATA_W-1]}}, r_b};
        w_s_x   = {{(TW-DATA_W){w_simm[DATA_W-1]}}, w_simm};
        w_prod  = r_neg ? -{1'b0, r_acc} : {1'b0, r_acc};
        w_true  = (r_op == OP_LOAD) ? w_s_x :
                  (r_op == OP_ADD)  ? w_a_x + w_b_x :
                  (r_op == OP_ADDI) ? w_a_x + w_s_x :
                  (r_op == OP_SUB)  ? w_a_x - w_b_x :
                  (r_op == OP_SUBI) ? w_a_x - w_s_x :
                  (r_op == OP_MUL)  ? w_prod : '0;
        w_hi    = w_true[TW-1:DATA_W-1];
        w_ovf   = !((&w_hi) || !(|w_hi));
        w_res   = (SAT_EN != 0 && w_ovf) ?
                  (w_true[TW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}}) :
                  w_true[DATA_W-1:0];
    end
    // Control FSM, shift-add multiplier datapath and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_imm_sign <= 1'b0;
            r_imm      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_store    <= 1'b0;
            r_zero     <= 1'b0;
            r_negf     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_op       <= opcode;
                    r_imm_sign <= imm_sign;
                    r_imm      <= imm;
                    r_a        <= src_a;
                    r_b        <= src_b;
                    r_acc      <= '0;
                    r_mcand    <= {{IMM_W{1'b0}}, w_a_mag};
                    r_mplier   <= imm;
                    r_cnt      <= '0;
                    r_neg      <= src_a[DATA_W-1] ^ imm_sign;
                    r_state    <= (opcode == OP_MUL) ? MUL_ITER : EXEC;
                end
                MUL_ITER: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(IMM_W - 1)) r_state <= EXEC;
                end
                EXEC: begin
                    if (r_op != OP_DISP) begin
                        r_result <= w_res;
                        r_zero   <= (w_res == '0);
                        r_negf   <= w_res[DATA_W-1];
                        r_ovf    <= w_ovf;
                    end
                    r_valid <= 1'b1;
                    r_store <= (r_op != OP_DISP);
                    r_state <= DONE;
                end
                DONE: begin
                    r_valid <= 1'b0;
                    r_store <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy         = (r_state != IDLE);
    assign result       = r_result;
    assign result_valid = r_valid;
    assign store_en     = r_store;
    assign flag_zero    = r_zero;
    assign flag_neg     = r_negf;
    assign flag_ovf     = r_ovf;
endmodule

// File: tb/tb_module_alu_seq.sv
// tb_module_alu_seq: scoreboard bench driving wrap and saturating ALU instances in lockstep
module tb_module_alu_seq;
    localparam int DW = 16;
    localparam int IW = 6;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [2:0] opcode = '0;
    logic imm_sign = 1'b0;
    logic [IW-1:0] imm = '0;
    logic [DW-1:0] src_a = '0;
    logic [DW-1:0] src_b = '0;
    logic [1:0] busy, valid, store, fz, fn, fo;
    logic [DW-1:0] res [2];
    int tests = 0;
    int fails = 0;
    longint cyc = 0;
    typedef struct {
        logic [1:0][DW-1:0] res;
        logic [1:0] z, n, o;
        logic st;
        longint exp_cyc;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    logic [1:0][DW-1:0] m_res = '0;
    logic [1:0] m_z = '0, m_n = '0, m_o = '0;

    module_alu_seq #(.DATA_W(DW), .IMM_W(IW), .SAT_EN(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .imm_sign(imm_sign), .imm(imm),
        .src_a(src_a), .src_b(src_b), .busy(busy[0]), .result(res[0]), .result_valid(valid[0]),
        .store_en(store[0]), .flag_zero(fz[0]), .flag_neg(fn[0]), .flag_ovf(fo[0]));
    module_alu_seq #(.DATA_W(DW), .IMM_W(IW), .SAT_EN(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .imm_sign(imm_sign), .imm(imm),
        .src_a(src_a), .src_b(src_b), .busy(busy[1]), .result(res[1]), .result_valid(valid[1]),
        .store_en(store[1]), .flag_zero(fz[1]), .flag_neg(fn[1]), .flag_ovf(fo[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer arithmetic, then range check, clamp or truncate
    task automatic model(input logic [2:0] op, input logic s, input logic [IW-1:0] im,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, output exp_t e);
        longint sa, sb, si, t;
        logic ov;
        logic [DW-1:0] r;
        sa = $signed(a);
        sb = $signed(b);
        si = s ? -longint'(im) : longint'(im);
        if (op != 3'd7) begin
            case (op)
                3'd0: t = si;
                3'd1: t = sa + sb;
                3'd2: t = sa + si;
                3'd3: t = sa - sb;
                3'd4: t = sa - si;
                3'd5: t = sa * si;
                default: t = 0;
            endcase
            ov = (t > 32767) || (t < -32768);
            for (int k = 0; k < 2; k++) begin
                r = (k == 1 && ov) ? ((t > 0) ? 16'h7FFF : 16'h8000) : DW'(t);
                m_res[k] = r;
                m_z[k] = (r == 0);
                m_n[k] = r[DW-1];
                m_o[k] = ov;
            end
        end
        e.res = m_res;
        e.z = m_z;
        e.n = m_n;
        e.o = m_o;
        e.st = (op != 3'd7);
        e.exp_cyc = 0;
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), busy[k], 0);
            chk($sformatf("%s_res%0d", tag, k), res[k], 0);
            chk($sformatf("%s_valid%0d", tag, k), valid[k], 0);
            chk($sformatf("%s_store%0d", tag, k), store[k], 0);
            chk($sformatf("%s_flags%0d", tag, k), {fz[k], fn[k], fo[k]}, 0);
        end
    endtask

    // Issue one request from an idle negedge; while busy, throw random starts at the DUT
    task automatic do_op(input logic [2:0] op, input logic s, input logic [IW-1:0] im,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        int g, bl, lat;
        g = 0;
        while (busy[0] && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("idle_wait", busy[0], 0);
        lat = (op == 3'd5) ? IW + 2 : 2;
        model(op, s, im, a, b, e);
        e.exp_cyc = cyc + lat;
        q.push_back(e);
        start = 1'b1;
        opcode = op;
        imm_sign = s;
        imm = im;
        src_a = a;
        src_b = b;
        @(negedge clk);
        bl = 0;
        while (busy[0] && bl < 50) begin
            bl++;
            start = 1'($urandom);
            opcode = 3'($urandom);
            imm_sign = 1'($urandom);
            imm = IW'($urandom);
            src_a = DW'($urandom);
            src_b = DW'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_len", bl, lat);
    endtask

    function automatic logic [DW-1:0] pick();
        logic [DW-1:0] tbl [4] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
        return ($urandom_range(3) == 0) ? tbl[$urandom_range(3)] : DW'($urandom);
    endfunction

    // Monitor: every result pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (valid[0] || valid[1]) begin
            if (q.size() == 0) chk("spurious_valid", valid, 0);
            else begin
                mon_e = q.pop_front();
                chk("latency", cyc, mon_e.exp_cyc);
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("valid%0d", k), valid[k], 1);
                    chk($sformatf("result%0d", k), res[k], mon_e.res[k]);
                    chk($sformatf("zero%0d", k), fz[k], mon_e.z[k]);
                    chk($sformatf("neg%0d", k), fn[k], mon_e.n[k]);
                    chk($sformatf("ovf%0d", k), fo[k], mon_e.o[k]);
                    chk($sformatf("store%0d", k), store[k], mon_e.st);
                end
            end
        end else if (q.size() > 0 && cyc > q[0].exp_cyc) begin
            chk("late_valid", valid[0], 1);
            void'(q.pop_front());
        end
    end

    initial begin
        int g;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        do_op(3'd1, 1'b0, 6'd0, 16'h7FFF, 16'h0001);
        do_op(3'd4, 1'b1, 6'd3, 16'h0005, 16'h1234);
        do_op(3'd0, 1'b1, 6'd0, 16'hABCD, 16'h5555);
        do_op(3'd5, 1'b1, 6'd5, 16'h0010, 16'h0000);
        do_op(3'd1, 1'b0, 6'd0, 16'h0001, 16'h0002);
        do_op(3'd7, 1'b1, 6'd9, 16'h7777, 16'h8888);
        do_op(3'd5, 1'b0, 6'd4, 16'h4000, 16'h0000);
        do_op(3'd5, 1'b1, 6'd63, 16'h8000, 16'h0000);
        do_op(3'd3, 1'b0, 6'd0, 16'h8000, 16'h0001);
        do_op(3'd2, 1'b1, 6'd63, 16'h8000, 16'h0000);
        do_op(3'd6, 1'b0, 6'd0, 16'h1234, 16'h4321);
        repeat (150) do_op(3'($urandom), 1'($urandom), IW'($urandom), pick(), pick());
        start = 1'b1;
        opcode = 3'd5;
        imm_sign = 1'b0;
        imm = 6'd4;
        src_a = 16'h4000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        m_res = '0;
        m_z = '0;
        m_n = '0;
        m_o = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'd7, 1'b0, 6'd1, 16'h1111, 16'h2222);
        do_op(3'd1, 1'b0, 6'd0, 16'h0003, 16'hFFFF);
        g = 0;
        while (q.size() > 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (q.size() > 0) chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
